// File: rtl/nfca_rx_tobytes_if.sv
// Receive framing bus between the NFC-A bit parser and the byte/frame consumer.
// master drives the parsed bit stream and reads bytes/frames; slave is the framer.
interface nfca_rx_tobytes_if;
  // Parsed bit stream and end-of-communication events
  logic       rx_bit_en;
  logic       rx_bit;
  logic       rx_end;
  logic       rx_end_col;
  logic       rx_end_err;
  // Byte strobe
  logic       rx_byte_en;
  logic [7:0] rx_byte;
  logic [3:0] rx_byte_bits;
  logic       rx_byte_perr;
  // Frame summary strobe
  logic       rx_frame_end;
  logic [7:0] rx_frame_bytes;
  logic [2:0] rx_frame_bits;
  logic       rx_frame_col;
  logic       rx_frame_perr;
  logic       rx_frame_err;

  modport master (
    output rx_bit_en, rx_bit, rx_end, rx_end_col, rx_end_err,
    input  rx_byte_en, rx_byte, rx_byte_bits, rx_byte_perr,
    input  rx_frame_end, rx_frame_bytes, rx_frame_bits, rx_frame_col, rx_frame_perr,
    input  rx_frame_err
  );

  modport slave (
    input  rx_bit_en, rx_bit, rx_end, rx_end_col, rx_end_err,
    output rx_byte_en, rx_byte, rx_byte_bits, rx_byte_perr,
    output rx_frame_end, rx_frame_bytes, rx_frame_bits, rx_frame_col, rx_frame_perr,
    output rx_frame_err
  );
endinterface

// File: rtl/nfca_rx_tobytes.sv
// NFC-A receive framer: groups parsed PICC bits LSB-first into bytes, checks odd
// parity after each full byte, reports a partial trailing byte and closes every
// frame with a one-cycle summary pulse.
module nfca_rx_tobytes #(
  parameter int unsigned MAX_BYTES = 64
) (
  input logic               clk,
  input logic               rstn,
  nfca_rx_tobytes_if.slave  io_rx
);

  localparam logic [1:0] ST_RECV    = 2'd0;
  localparam logic [1:0] ST_DISCARD = 2'd1;
  localparam logic [1:0] ST_CLOSE   = 2'd2;

  localparam logic [7:0] LP_MAX_BYTES = 8'(MAX_BYTES);

  // Frame state
  logic [1:0] r_state, w_state;
  logic [7:0] r_data,  w_data;
  logic [3:0] r_pos,   w_pos;
  logic [7:0] r_bytes, w_bytes;
  logic       r_perr,  w_perr;
  logic       r_ovf,   w_ovf;
  logic       r_col,   w_col;   // end cause held for the CLOSE cycle
  logic       r_err,   w_err;

  // Registered outputs
  logic       r_byte_en,     w_byte_en;
  logic [7:0] r_byte,        w_byte;
  logic [3:0] r_byte_bits,   w_byte_bits;
  logic       r_byte_perr,   w_byte_perr;
  logic       r_frame_end,   w_frame_end;
  logic [7:0] r_frame_bytes, w_frame_bytes;
  logic [2:0] r_frame_bits,  w_frame_bits;
  logic       r_frame_col,   w_frame_col;
  logic       r_frame_perr,  w_frame_perr;
  logic       r_frame_err,   w_frame_err;

  // Next-state and output decode; a bit in the same cycle as rx_end is handled first
  always_comb begin
    w_state       = r_state;
    w_data        = r_data;
    w_pos         = r_pos;
    w_bytes       = r_bytes;
    w_perr        = r_perr;
    w_ovf         = r_ovf;
    w_col         = r_col;
    w_err         = r_err;
    w_byte_en     = 1'b0;
    w_byte        = 8'd0;
    w_byte_bits   = 4'd0;
    w_byte_perr   = 1'b0;
    w_frame_end   = 1'b0;
    w_frame_bytes = 8'd0;
    w_frame_bits  = 3'd0;
    w_frame_col   = 1'b0;
    w_frame_perr  = 1'b0;
    w_frame_err   = 1'b0;

    case (r_state)
      ST_RECV: begin
        if (io_rx.rx_bit_en) begin
          if (r_pos == 4'd8) begin
            // Parity bit: total ones over data+parity must be odd
            w_byte_en   = 1'b1;
            w_byte      = r_data;
            w_byte_bits = 4'd8;
            w_byte_perr = ~^{io_rx.rx_bit, r_data};
            w_bytes     = r_bytes + 8'd1;
            w_perr      = r_perr | w_byte_perr;
            w_pos       = 4'd0;
            w_data      = 8'd0;
          end else if (r_bytes == LP_MAX_BYTES) begin
            w_ovf   = 1'b1;
            w_state = ST_DISCARD;
          end else begin
            w_data[r_pos[2:0]] = io_rx.rx_bit;
            w_pos              = r_pos + 4'd1;
          end
        end
        if (io_rx.rx_end) begin
          // Tail byte only while still collecting; it is not counted as a full byte
          if (w_state == ST_RECV && w_pos != 4'd0) begin
            w_byte_en   = 1'b1;
            w_byte      = w_data;
            w_byte_bits = w_pos;
            w_byte_perr = 1'b0;
          end
          w_state = ST_CLOSE;
          w_col   = io_rx.rx_end_col;
          w_err   = io_rx.rx_end_err;
        end
      end

      ST_DISCARD: begin
        if (io_rx.rx_end) begin
          w_state = ST_CLOSE;
          w_col   = io_rx.rx_end_col;
          w_err   = io_rx.rx_end_err;
        end
      end

      ST_CLOSE: begin
        w_frame_end   = 1'b1;
        w_frame_bytes = r_bytes;
        w_frame_bits  = (r_pos == 4'd8) ? 3'd0 : r_pos[2:0];
        w_frame_col   = r_col;
        w_frame_perr  = r_perr;
        w_frame_err   = r_err | r_ovf;
        w_state       = ST_RECV;
        w_data        = 8'd0;
        w_pos         = 4'd0;
        w_bytes       = 8'd0;
        w_perr        = 1'b0;
        w_ovf         = 1'b0;
        w_col         = 1'b0;
        w_err         = 1'b0;
      end

      default: w_state = ST_RECV;
    endcase
  end

  // State and output registers, synchronous active-low reset drops any partial frame
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= ST_RECV;
      r_data        <= 8'd0;
      r_pos         <= 4'd0;
      r_bytes       <= 8'd0;
      r_perr        <= 1'b0;
      r_ovf         <= 1'b0;
      r_col         <= 1'b0;
      r_err         <= 1'b0;
      r_byte_en     <= 1'b0;
      r_byte        <= 8'd0;
      r_byte_bits   <= 4'd0;
      r_byte_perr   <= 1'b0;
      r_frame_end   <= 1'b0;
      r_frame_bytes <= 8'd0;
      r_frame_bits  <= 3'd0;
      r_frame_col   <= 1'b0;
      r_frame_perr  <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_data        <= w_data;
      r_pos         <= w_pos;
      r_bytes       <= w_bytes;
      r_perr        <= w_perr;
      r_ovf         <= w_ovf;
      r_col         <= w_col;
      r_err         <= w_err;
      r_byte_en     <= w_byte_en;
      r_byte        <= w_byte;
      r_byte_bits   <= w_byte_bits;
      r_byte_perr   <= w_byte_perr;
      r_frame_end   <= w_frame_end;
      r_frame_bytes <= w_frame_bytes;
      r_frame_bits  <= w_frame_bits;
      r_frame_col   <= w_frame_col;
      r_frame_perr  <= w_frame_perr;
      r_frame_err   <= w_frame_err;
    end
  end

  assign io_rx.rx_byte_en     = r_byte_en;
  assign io_rx.rx_byte        = r_byte;
  assign io_rx.rx_byte_bits   = r_byte_bits;
  assign io_rx.rx_byte_perr   = r_byte_perr;
  assign io_rx.rx_frame_end   = r_frame_end;
  assign io_rx.rx_frame_bytes = r_frame_bytes;
  assign io_rx.rx_frame_bits  = r_frame_bits;
  assign io_rx.rx_frame_col   = r_frame_col;
  assign io_rx.rx_frame_perr  = r_frame_perr;
  assign io_rx.rx_frame_err   = r_frame_err;

endmodule
